// File: rtl/led_pkg.sv
// Shared types and register offsets for the LED MMIO controller.
package led_pkg;

    typedef enum logic [1:0] {
        STATIC = 2'd0,
        BLINK  = 2'd1,
        ROTL   = 2'd2,
        ROTR   = 2'd3
    } led_mode_e;

    localparam logic [3:0] DATA   = 4'h0;
    localparam logic [3:0] MODE   = 4'h4;
    localparam logic [3:0] PERIOD = 4'h8;
    localparam logic [3:0] STATUS = 4'hC;

endpackage

// File: rtl/led_mmio_ctrl_if.sv
// Single-cycle CPU load/store bus seen by the LED register window.
interface led_mmio_ctrl_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/led_prescaler.sv
// Reloadable down-counter; ticks while enabled and at zero, then reloads.
module led_prescaler #(
    parameter int                  PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = 24'd5_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                reload_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] count_q, count_d;

    // A period of zero reloads to zero, so the counter ticks every cycle.
    always_comb begin
        count_d = count_q;
        if (reload_i) begin
            count_d = period_i;
        end else if (en_i) begin
            count_d = (count_q == '0) ? period_i : count_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= PERIOD_RST;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = en_i && (count_q == '0);

endmodule

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED pattern controller: static, blink and rotate modes
// paced by a prescaler, emitting one-cycle load strobes downstream.
module led_mmio_ctrl
    import led_pkg::*;
#(
    parameter logic [31:0]         LED_BASE   = 32'hFFFF_0000,
    parameter int                  PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = 24'd5_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    led_mmio_ctrl_if.slave        bus,
    output logic [7:0]            led_load_data,
    output logic                  led_load
);

    logic [7:0]          pattern_q, pattern_d;
    led_mode_e           mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                phase_q, phase_d;
    logic                load_q, load_d;
    logic [7:0]          load_data_q, load_data_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;

    logic       hit, wr, rd, tick, presc_reload;
    logic [3:0] off;

    assign hit = (bus.bus_addr[31:4] == LED_BASE[31:4]);
    assign wr  = hit && bus.bus_we;
    assign rd  = hit && bus.bus_re && !bus.bus_we;
    assign off = {bus.bus_addr[3:2], 2'b00};

    led_prescaler #(
        .PERIOD_W   (PERIOD_W),
        .PERIOD_RST (PERIOD_RST)
    ) u_presc (
        .clk      (clk),
        .rst      (rst),
        .en_i     (mode_q != STATIC),
        .reload_i (presc_reload),
        .period_i (period_q),
        .tick_o   (tick)
    );

    always_comb begin
        pattern_d    = pattern_q;
        mode_d       = mode_q;
        period_d     = period_q;
        phase_d      = phase_q;
        load_d       = 1'b0;
        load_data_d  = load_data_q;
        ready_d      = wr || rd;
        rdata_d      = 32'h0;
        presc_reload = 1'b0;

        // An accepted write swallows a coincident tick.
        if (wr) begin
            case (off)
                DATA: begin
                    pattern_d   = bus.bus_wdata[7:0];
                    load_d      = 1'b1;
                    load_data_d = bus.bus_wdata[7:0];
                end
                MODE: begin
                    mode_d       = led_mode_e'(bus.bus_wdata[1:0]);
                    presc_reload = 1'b1;
                    phase_d      = 1'b1;
                    load_d       = 1'b1;
                    load_data_d  = pattern_q;
                end
                PERIOD:  period_d = bus.bus_wdata[PERIOD_W-1:0];
                default: ;
            endcase
        end else if (tick) begin
            case (mode_q)
                BLINK: begin
                    phase_d     = !phase_q;
                    load_d      = 1'b1;
                    load_data_d = phase_q ? 8'h00 : pattern_q;
                end
                ROTL: begin
                    pattern_d   = {pattern_q[6:0], pattern_q[7]};
                    load_d      = 1'b1;
                    load_data_d = {pattern_q[6:0], pattern_q[7]};
                end
                ROTR: begin
                    pattern_d   = {pattern_q[0], pattern_q[7:1]};
                    load_d      = 1'b1;
                    load_data_d = {pattern_q[0], pattern_q[7:1]};
                end
                default: ;
            endcase
        end

        if (rd) begin
            case (off)
                DATA:    rdata_d = {24'h0, pattern_q};
                MODE:    rdata_d = {30'h0, mode_q};
                PERIOD:  rdata_d = 32'(period_q);
                default: rdata_d = {21'h0, phase_q, mode_q, load_data_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= 8'h00;
            mode_q      <= STATIC;
            period_q    <= PERIOD_RST;
            phase_q     <= 1'b1;
            load_q      <= 1'b0;
            load_data_q <= 8'h00;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            pattern_q   <= pattern_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            phase_q     <= phase_d;
            load_q      <= load_d;
            load_data_q <= load_data_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
        end
    end

    assign led_load      = load_q;
    assign led_load_data = load_data_q;
    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Directed bench for led_mmio_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_led_mmio_ctrl;

    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_DATA   = BASE + 32'h0;
    localparam logic [31:0] A_MODE   = BASE + 32'h4;
    localparam logic [31:0] A_PERIOD = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;
    localparam logic [31:0] A_OUT    = BASE + 32'h10;
    localparam logic [31:0] P_RST    = 32'h004C_4B40;

    logic       clk;
    logic       rst;
    logic       led_load;
    logic [7:0] led_load_data;
    int         n_cmp;
    int         n_bad;
    logic [31:0] rd_d;
    logic        rd_r;
    logic [7:0]  rotl_exp [3];

    led_mmio_ctrl_if bus_if ();

    led_mmio_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .led_load_data (led_load_data),
        .led_load      (led_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus_if.bus_we    = we;
        bus_if.bus_re    = re;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Returns on the falling edge where the access result is visible.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        drive(1'b1, 1'b0, addr, wdata);
        @(negedge clk);
        idle();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic r);
        drive(1'b0, 1'b1, addr, 32'h0);
        @(negedge clk);
        idle();
        d = bus_if.bus_rdata;
        r = bus_if.bus_ready;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rotl_exp[0] = 8'h03;
        rotl_exp[1] = 8'h06;
        rotl_exp[2] = 8'h0C;
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_load",  32'(led_load), 32'h0);
        chk("rst_ldata", 32'(led_load_data), 32'h0);
        chk("rst_ready", 32'(bus_if.bus_ready), 32'h0);
        chk("rst_rdata", bus_if.bus_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_load", 32'(led_load), 32'h0);

        bus_read(A_PERIOD, rd_d, rd_r);
        chk("rd_period_ready", 32'(rd_r), 32'h1);
        chk("rd_period_data", rd_d, P_RST);
        chk("rd_period_load", 32'(led_load), 32'h0);
        @(negedge clk);
        chk("ready_one_cycle", 32'(bus_if.bus_ready), 32'h0);
        chk("rdata_idle_zero", bus_if.bus_rdata, 32'h0);

        bus_write(A_DATA, 32'h0000_01A5);
        chk("wr_data_ready", 32'(bus_if.bus_ready), 32'h1);
        chk("wr_data_rdata", bus_if.bus_rdata, 32'h0);
        chk("wr_data_load", 32'(led_load), 32'h1);
        chk("wr_data_ldata", 32'(led_load_data), 32'hA5);
        @(negedge clk);
        chk("load_single", 32'(led_load), 32'h0);
        chk("ldata_held", 32'(led_load_data), 32'hA5);

        // STATUS = {phase=1, mode=STATIC, last load=A5}
        bus_read(A_STATUS, rd_d, rd_r);
        chk("status_static", rd_d, 32'h0000_04A5);
        bus_read(A_DATA, rd_d, rd_r);
        chk("rd_data_a5", rd_d, 32'h0000_00A5);
        bus_read(A_MODE, rd_d, rd_r);
        chk("rd_mode_static", rd_d, 32'h0);

        bus_write(A_STATUS, 32'hFFFF_FFFF);
        chk("wr_status_ready", 32'(bus_if.bus_ready), 32'h1);
        chk("wr_status_noload", 32'(led_load), 32'h0);
        bus_read(A_STATUS, rd_d, rd_r);
        chk("status_unchanged", rd_d, 32'h0000_04A5);

        bus_write(A_OUT, 32'h55);
        chk("out_wr_ready", 32'(bus_if.bus_ready), 32'h0);
        chk("out_wr_load", 32'(led_load), 32'h0);
        bus_read(A_OUT, rd_d, rd_r);
        chk("out_rd_ready", 32'(rd_r), 32'h0);
        chk("out_rd_rdata", rd_d, 32'h0);
        bus_read(A_DATA, rd_d, rd_r);
        chk("out_no_change", rd_d, 32'h0000_00A5);

        drive(1'b1, 1'b1, A_DATA, 32'h3C);
        @(negedge clk);
        idle();
        chk("wr_rd_ready", 32'(bus_if.bus_ready), 32'h1);
        chk("wr_rd_rdata", bus_if.bus_rdata, 32'h0);
        chk("wr_rd_load", 32'(led_load), 32'h1);
        chk("wr_rd_ldata", 32'(led_load_data), 32'h3C);

        bus_write(A_PERIOD, 32'd2);
        chk("wr_period_noload", 32'(led_load), 32'h0);
        bus_write(A_DATA, 32'h81);
        chk("rotl_data_ldata", 32'(led_load_data), 32'h81);
        bus_write(A_MODE, 32'd2);
        chk("rotl_mode_load", 32'(led_load), 32'h1);
        chk("rotl_mode_ldata", 32'(led_load_data), 32'h81);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rotl_gap1", 32'(led_load), 32'h0);
            @(negedge clk);
            chk("rotl_gap2", 32'(led_load), 32'h0);
            @(negedge clk);
            chk("rotl_load", 32'(led_load), 32'h1);
            chk("rotl_ldata", 32'(led_load_data), 32'(rotl_exp[i]));
        end
        bus_read(A_DATA, rd_d, rd_r);
        chk("rotl_stored", rd_d, 32'h0000_000C);

        // Next write lands exactly in the tick cycle.
        @(negedge clk);
        bus_write(A_DATA, 32'h5A);
        chk("tickwr_load", 32'(led_load), 32'h1);
        chk("tickwr_ldata", 32'(led_load_data), 32'h5A);
        @(negedge clk);
        chk("tickwr_single", 32'(led_load), 32'h0);
        @(negedge clk);
        chk("tickwr_gap", 32'(led_load), 32'h0);
        @(negedge clk);
        chk("tickwr_next_load", 32'(led_load), 32'h1);
        chk("tickwr_next_ldata", 32'(led_load_data), 32'hB4);

        bus_write(A_MODE, 32'd0);
        chk("static_ldata", 32'(led_load_data), 32'hB4);
        bus_write(A_PERIOD, 32'd0);
        bus_write(A_DATA, 32'hF0);
        bus_write(A_MODE, 32'd1);
        chk("blink_mode_load", 32'(led_load), 32'h1);
        chk("blink_mode_ldata", 32'(led_load_data), 32'hF0);
        @(negedge clk);
        chk("blink_1_load", 32'(led_load), 32'h1);
        chk("blink_1_ldata", 32'(led_load_data), 32'h00);
        drive(1'b0, 1'b1, A_STATUS, 32'h0);
        @(negedge clk);
        idle();
        chk("blink_2_load", 32'(led_load), 32'h1);
        chk("blink_2_ldata", 32'(led_load_data), 32'hF0);
        chk("blink_status", bus_if.bus_rdata, 32'h0000_0100);
        @(negedge clk);
        chk("blink_3_load", 32'(led_load), 32'h1);
        chk("blink_3_ldata", 32'(led_load_data), 32'h00);

        bus_write(A_MODE, 32'd3);
        chk("rotr_mode_ldata", 32'(led_load_data), 32'hF0);
        @(negedge clk);
        chk("rotr_1_ldata", 32'(led_load_data), 32'h78);
        @(negedge clk);
        chk("rotr_2_load", 32'(led_load), 32'h1);
        chk("rotr_2_ldata", 32'(led_load_data), 32'h3C);

        rst = 1'b1;
        drive(1'b0, 1'b1, A_DATA, 32'h0);
        @(negedge clk);
        idle();
        chk("mid_rst_load", 32'(led_load), 32'h0);
        chk("mid_rst_ldata", 32'(led_load_data), 32'h0);
        chk("mid_rst_ready", 32'(bus_if.bus_ready), 32'h0);
        chk("mid_rst_rdata", bus_if.bus_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_load", 32'(led_load), 32'h0);
        chk("after_rst_ready", 32'(bus_if.bus_ready), 32'h0);
        bus_read(A_MODE, rd_d, rd_r);
        chk("after_rst_mode", rd_d, 32'h0);
        bus_read(A_DATA, rd_d, rd_r);
        chk("after_rst_data", rd_d, 32'h0);
        bus_read(A_PERIOD, rd_d, rd_r);
        chk("after_rst_period", rd_d, P_RST);
        bus_read(A_STATUS, rd_d, rd_r);
        chk("after_rst_status", rd_d, 32'h0000_0400);
        chk("after_rst_noload", 32'(led_load), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
